ets_phase_sequencer: RTL and testbench

//  Parametrised successor of the fixed 10-phase GTH word mux and the fixed divide-by-10 trigger.

---
 rtl/ets_phase_sequencer.sv | 147 ++++++++++++++
 tb/tb_ets_phase_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ets_phase_sequencer.sv
// Plays a writable pattern table onto the GTH TX word, one word per cycle, with periodic trigger and run control.
// Latency: start sampled to first word on gth_data is 1 cycle; table writes are visible from the next read onward.
// Backpressure: none; the GTH port accepts a word every cycle, and start/stop are plain levels sampled each cycle.
module ets_phase_sequencer #(
    parameter int DATA_W     = 80,
    parameter int NUM_PHASES = 16,
    parameter int IDX_W      = 4,
    parameter int DIV_W      = 8,
    parameter int BURST_W    = 16
) (
    input  logic                free_run_clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_addr,
    input  logic [DATA_W-1:0]   cfg_wdata,
    input  logic [IDX_W:0]      cfg_num_phases,
    input  logic [DIV_W-1:0]    cfg_div,
    input  logic [BURST_W-1:0]  cfg_burst,
    input  logic                start,
    input  logic                stop,
    output logic [DATA_W-1:0]   gth_data,
    output logic [IDX_W-1:0]    phase_idx,
    output logic                trig_pulse,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  tbl [NUM_PHASES];

    // Run configuration captured at start; later config changes do not disturb a run.
    logic [IDX_W:0]     n_lat;
    logic [DIV_W-1:0]   d_lat;
    logic [BURST_W-1:0] b_lat;

    // Period number of the word on gth_data, and that period number modulo (D+1).
    logic [BURST_W-1:0] per_cnt;
    logic [DIV_W-1:0]   div_cnt;

    logic [IDX_W:0]     n_clamp;
    logic               last_phase;
    logic               burst_last;
    logic [IDX_W-1:0]   nxt_idx;
    logic [DIV_W-1:0]   nxt_div;

    // Clamp the requested period length into 1..NUM_PHASES.
    always_comb begin
        n_clamp = cfg_num_phases;
        if (cfg_num_phases == '0)
            n_clamp = (IDX_W+1)'(1);
        else if (cfg_num_phases > (IDX_W+1)'(NUM_PHASES))
            n_clamp = (IDX_W+1)'(NUM_PHASES);
    end

    // Position decode for the word currently on gth_data and the step to the next one.
    always_comb begin
        last_phase = ({1'b0, phase_idx} == (n_lat - (IDX_W+1)'(1)));
        burst_last = (b_lat != '0) && (per_cnt == (b_lat - BURST_W'(1)));
        nxt_idx    = last_phase ? '0 : (phase_idx + IDX_W'(1));
        nxt_div    = (div_cnt == d_lat) ? '0 : (div_cnt + DIV_W'(1));
    end

    // Pattern table: cleared by reset, writable at any time; out-of-range addresses are dropped.
    // Reads in the sequencer use the pre-edge contents, so a same-edge write shows the old word.
    always_ff @(posedge free_run_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PHASES; i++)
                tbl[i] <= '0;
        end else if (cfg_we && ({1'b0, cfg_addr} < (IDX_W+1)'(NUM_PHASES))) begin
            tbl[cfg_addr] <= cfg_wdata;
        end
    end

    // Run-control FSM with all outputs registered.
    always_ff @(posedge free_run_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            n_lat      <= (IDX_W+1)'(1);
            d_lat      <= '0;
            b_lat      <= '0;
            per_cnt    <= '0;
            div_cnt    <= '0;
            gth_data   <= '0;
            phase_idx  <= '0;
            trig_pulse <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done       <= 1'b0;
            trig_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    gth_data  <= '0;
                    phase_idx <= '0;
                    busy      <= 1'b0;
                    // start wins over a simultaneous stop; stop alone is meaningless here.
                    if (start) begin
                        n_lat      <= n_clamp;
                        d_lat      <= cfg_div;
                        b_lat      <= cfg_burst;
                        per_cnt    <= '0;
                        div_cnt    <= '0;
                        gth_data   <= tbl[0];
                        phase_idx  <= '0;
                        trig_pulse <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN, ST_STOPPING: begin
                    // A run ends after the last phase of the final burst period, or of the
                    // current period once stop has been seen (including stop on that last phase).
                    if (last_phase && (burst_last || state == ST_STOPPING || stop)) begin
                        gth_data  <= '0;
                        phase_idx <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        gth_data  <= tbl[nxt_idx];
                        phase_idx <= nxt_idx;
                        if (last_phase) begin
                            per_cnt    <= per_cnt + BURST_W'(1);
                            div_cnt    <= nxt_div;
                            trig_pulse <= (nxt_div == '0);
                        end
                        if (state == ST_RUN && stop)
                            state <= ST_STOPPING;
                    end
                end
                default: begin
                    gth_data  <= '0;
                    phase_idx <= '0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ets_phase_sequencer.sv
// Directed bench for ets_phase_sequencer: burst, stop, clamping, same-edge table write, reset abort, start/stop corner cases.
// Latency: inputs change 1ns after a rising edge, outputs are checked 1ns after the following rising edge.
// Backpressure: none exercised; the design has no ready input.
module tb_ets_phase_sequencer;

    localparam int DATA_W     = 80;
    localparam int NUM_PHASES = 16;
    localparam int IDX_W      = 4;
    localparam int DIV_W      = 8;
    localparam int BURST_W    = 16;

    logic                free_run_clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                cfg_we = 1'b0;
    logic [IDX_W-1:0]    cfg_addr = '0;
    logic [DATA_W-1:0]   cfg_wdata = '0;
    logic [IDX_W:0]      cfg_num_phases = '0;
    logic [DIV_W-1:0]    cfg_div = '0;
    logic [BURST_W-1:0]  cfg_burst = '0;
    logic                start = 1'b0;
    logic                stop = 1'b0;
    logic [DATA_W-1:0]   gth_data;
    logic [IDX_W-1:0]    phase_idx;
    logic                trig_pulse;
    logic                busy;
    logic                done;

    int tests = 0;
    int fails = 0;

    ets_phase_sequencer #(
        .DATA_W(DATA_W), .NUM_PHASES(NUM_PHASES), .IDX_W(IDX_W), .DIV_W(DIV_W), .BURST_W(BURST_W)
    ) dut (
        .free_run_clk(free_run_clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_num_phases(cfg_num_phases), .cfg_div(cfg_div), .cfg_burst(cfg_burst),
        .start(start), .stop(stop),
        .gth_data(gth_data), .phase_idx(phase_idx), .trig_pulse(trig_pulse),
        .busy(busy), .done(done)
    );

    always #5 free_run_clk = ~free_run_clk;

    task automatic tick();
        @(posedge free_run_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check the full output set in one call.
    task automatic chk_out(input string tag, input logic [DATA_W-1:0] d, input int ph,
                           input logic tr, input logic bz, input logic dn);
        chk({tag, ".data"}, gth_data, d);
        chk({tag, ".phase"}, {76'd0, phase_idx}, DATA_W'(ph));
        chk({tag, ".trig"}, {79'd0, trig_pulse}, {79'd0, tr});
        chk({tag, ".busy"}, {79'd0, busy}, {79'd0, bz});
        chk({tag, ".done"}, {79'd0, done}, {79'd0, dn});
    endtask

    task automatic wr(input int a, input int v);
        cfg_we    = 1'b1;
        cfg_addr  = IDX_W'(a);
        cfg_wdata = DATA_W'(v);
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic go(input int n, input int d, input int b);
        cfg_num_phases = (IDX_W+1)'(n);
        cfg_div        = DIV_W'(d);
        cfg_burst      = BURST_W'(b);
        start          = 1'b1;
        tick();
        start          = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk_out("reset", '0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        chk_out("idle", '0, 0, 0, 0, 0);

        // 1: table[i]=i+1, N=10, D=9, B=3
        for (int i = 0; i < 10; i++) wr(i, i + 1);
        go(10, 9, 3);
        for (int k = 0; k < 30; k++) begin
            chk_out($sformatf("t1.k%0d", k), DATA_W'((k % 10) + 1), k % 10, (k == 0), 1, 0);
            tick();
        end
        chk_out("t1.done", '0, 0, 0, 0, 1);
        tick();
        chk_out("t1.after", '0, 0, 0, 0, 0);

        // 2: N=4, D=0, continuous, stop while phase 1 is output
        go(4, 0, 0);
        for (int k = 0; k < 9; k++) begin
            chk_out($sformatf("t2.k%0d", k), DATA_W'((k % 4) + 1), k % 4, (k % 4 == 0), 1, 0);
            tick();
        end
        chk_out("t2.ph1", 2, 1, 0, 1, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_out("t2.ph2", 3, 2, 0, 1, 0);
        tick();
        chk_out("t2.ph3", 4, 3, 0, 1, 0);
        tick();
        chk_out("t2.done", '0, 0, 0, 0, 1);
        tick();

        // 3a: cfg_num_phases=0 -> one-word periods, B=3
        go(0, 0, 3);
        for (int k = 0; k < 3; k++) begin
            chk_out($sformatf("t3a.k%0d", k), 1, 0, 1, 1, 0);
            tick();
        end
        chk_out("t3a.done", '0, 0, 0, 0, 1);
        tick();

        // 3b: cfg_num_phases=31 -> 16-word period, B=1
        go(31, 0, 1);
        for (int k = 0; k < 16; k++) begin
            chk_out($sformatf("t3b.k%0d", k), (k < 10) ? DATA_W'(k + 1) : '0, k, (k == 0), 1, 0);
            tick();
        end
        chk_out("t3b.done", '0, 0, 0, 0, 1);
        tick();

        // 4: write table[2] on the edge that loads phase 2
        go(4, 0, 2);
        chk_out("t4.ph0", 1, 0, 1, 1, 0);
        tick();
        chk_out("t4.ph1", 2, 1, 0, 1, 0);
        cfg_we = 1'b1; cfg_addr = 4'd2; cfg_wdata = 80'hAA;
        tick();
        cfg_we = 1'b0;
        chk_out("t4.old", 3, 2, 0, 1, 0);
        tick(); tick(); tick();
        chk_out("t4.p1ph1", 2, 1, 0, 1, 0);
        tick();
        chk_out("t4.new", 80'hAA, 2, 0, 1, 0);
        tick();
        chk_out("t4.p1ph3", 4, 3, 0, 1, 0);
        tick();
        chk_out("t4.done", '0, 0, 0, 0, 1);
        tick();

        // 5: reset during phase 5 of a continuous run
        go(10, 0, 0);
        for (int k = 0; k < 5; k++) tick();
        chk_out("t5.ph5", 6, 5, 0, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("t5.async", '0, 0, 0, 0, 0);
        tick(); tick();
        chk_out("t5.held", '0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        chk_out("t5.rel", '0, 0, 0, 0, 0);
        go(16, 0, 1);
        for (int k = 0; k < 16; k++) begin
            chk_out($sformatf("t5.tbl%0d", k), '0, k, (k == 0), 1, 0);
            tick();
        end
        chk_out("t5.done", '0, 0, 0, 0, 1);
        tick();

        // 6: start+stop in IDLE, start held across done, start pulse while busy
        for (int i = 0; i < 4; i++) wr(i, i + 1);
        cfg_num_phases = 5'd2; cfg_div = '0; cfg_burst = 16'd1;
        start = 1'b1; stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_out("t6.ss", 1, 0, 1, 1, 0);
        tick();
        chk_out("t6.ph1", 2, 1, 0, 1, 0);
        tick();
        chk_out("t6.done", '0, 0, 0, 0, 1);
        tick();
        start = 1'b0;
        chk_out("t6.restart", 1, 0, 1, 1, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_out("t6.busyst", 2, 1, 0, 1, 0);
        tick();
        chk_out("t6.done2", '0, 0, 0, 0, 1);
        tick();
        chk_out("t6.idle", '0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
